// File: rtl/clock_divider_if.sv
// Control/status bundle for clock_divider: run enable in, divided clock and wrap pulse out.
interface clock_divider_if;
  logic en;
  logic clk_out;
  logic tick;

  // The consumer drives en; the divider answers with clk_out and tick.
  modport master (output en, input clk_out, input tick);
  modport slave  (input en, output clk_out, output tick);
endinterface

// File: rtl/clock_divider.sv
// Divides clk by F into a registered square wave (low phase gets the odd cycle)
// plus a one-cycle tick at every period boundary.
module clock_divider #(
    parameter int unsigned F = 120000,
    localparam int unsigned CW = $clog2(F)
) (
    input  logic            clk,
    input  logic            reset,
    clock_divider_if.slave  bus,
    output logic [CW-1:0]   count
);

    if (F < 2) begin : g_bad_ratio
        $error("clock_divider: F must be at least 2");
    end

    localparam logic [CW-1:0] LAST    = CW'(F - 1);
    localparam logic [CW-1:0] LOW_LEN = CW'(F - F / 2);

    logic [CW-1:0] next_count;

    // Explicit wrap at F-1; the counter is never allowed to overflow naturally.
    always_comb begin
        next_count = count + CW'(1);
        if (count == LAST) begin
            next_count = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            bus.clk_out <= 1'b0;
            bus.tick    <= 1'b0;
        end else if (!bus.en) begin
            count       <= '0;
            bus.clk_out <= 1'b0;
            bus.tick    <= 1'b0;
        end else begin
            count       <= next_count;
            bus.clk_out <= (next_count >= LOW_LEN);
            bus.tick    <= (next_count == '0);
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: five instances with different ratios checked against an edge-count model.
module tb_clock_divider;

    localparam int FB = 12001;

    logic clk;
    logic reset;

    clock_divider_if if0 ();
    clock_divider_if if1 ();
    clock_divider_if if2 ();
    clock_divider_if if3 ();
    clock_divider_if if4 ();

    logic [1:0]  cnt0;
    logic [2:0]  cnt1;
    logic [0:0]  cnt2;
    logic [2:0]  cnt3;
    logic [13:0] cnt4;

    clock_divider #(.F(4))  u_f4   (.clk(clk), .reset(reset), .bus(if0), .count(cnt0));
    clock_divider #(.F(5))  u_f5   (.clk(clk), .reset(reset), .bus(if1), .count(cnt1));
    clock_divider #(.F(2))  u_f2   (.clk(clk), .reset(reset), .bus(if2), .count(cnt2));
    clock_divider #(.F(6))  u_f6   (.clk(clk), .reset(reset), .bus(if3), .count(cnt3));
    clock_divider #(.F(FB)) u_fbig (.clk(clk), .reset(reset), .bus(if4), .count(cnt4));

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: k = enabled edges since the last restart; outputs follow from k mod F.
    int k0 = 0, k1 = 0, k2 = 0, k3 = 0, k4 = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            k0 = 0; k1 = 0; k2 = 0; k3 = 0; k4 = 0;
        end else begin
            k0 = if0.en ? k0 + 1 : 0;
            k1 = if1.en ? k1 + 1 : 0;
            k2 = if2.en ? k2 + 1 : 0;
            k3 = if3.en ? k3 + 1 : 0;
            k4 = if4.en ? k4 + 1 : 0;
        end
    end

    task automatic chk(input string nm, input int f, input int k,
                       input logic co, input logic tk, input int cnt);
        int  m;
        logic exp_co;
        logic exp_tk;
        m      = k % f;
        exp_co = (m >= f - f / 2);
        exp_tk = (k > 0) && (m == 0);
        checks++;
        if (co !== exp_co) begin
            errors++;
            $display("FAIL %s clk_out: got %b expected %b (k=%0d)", nm, co, exp_co, k);
        end
        checks++;
        if (tk !== exp_tk) begin
            errors++;
            $display("FAIL %s tick: got %b expected %b (k=%0d)", nm, tk, exp_tk, k);
        end
        checks++;
        if (cnt != m) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", nm, cnt, m);
        end
    endtask

    always @(negedge clk) begin
        chk("f4",   4,  k0, if0.clk_out, if0.tick, int'(cnt0));
        chk("f5",   5,  k1, if1.clk_out, if1.tick, int'(cnt1));
        chk("f2",   2,  k2, if2.clk_out, if2.tick, int'(cnt2));
        chk("f6",   6,  k3, if3.clk_out, if3.tick, int'(cnt3));
        chk("fbig", FB, k4, if4.clk_out, if4.tick, int'(cnt4));
    end

    task automatic lit(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    logic lit4_clk  [8]  = '{0,1,1,0,0,1,1,0};
    logic lit4_tick [8]  = '{0,0,0,1,0,0,0,1};
    logic lit2_clk  [8]  = '{1,0,1,0,1,0,1,0};
    logic lit2_tick [8]  = '{0,1,0,1,0,1,0,1};
    logic lit5_clk  [10] = '{0,0,1,1,0,0,0,1,1,0};
    logic lit5_tick [10] = '{0,0,0,0,1,0,0,0,0,1};
    logic lit6_clk  [6]  = '{0,0,1,1,1,0};
    logic lit6_tick [6]  = '{0,0,0,0,0,1};
    int   lit6_cnt  [6]  = '{1,2,3,4,5,0};

    initial begin
        int   ticks;
        int   highs;
        int   period;
        logic prev;
        logic found;

        reset = 1'b1;
        if0.en = 1'b1; if1.en = 1'b1; if2.en = 1'b1; if3.en = 1'b1; if4.en = 1'b1;
        #1 reset = 1'b0;

        // Reset held with en = 1: everything stays cleared.
        repeat (4) @(negedge clk);
        lit("rst_clk_out", int'(if0.clk_out), 0);
        lit("rst_tick",    int'(if0.tick), 0);
        lit("rst_count",   int'(cnt0), 0);
        reset = 1'b1;

        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n < 8) begin
                lit($sformatf("f4_clk_e%0d", n + 1),  int'(if0.clk_out), int'(lit4_clk[n]));
                lit($sformatf("f4_tick_e%0d", n + 1), int'(if0.tick),    int'(lit4_tick[n]));
                lit($sformatf("f2_clk_e%0d", n + 1),  int'(if2.clk_out), int'(lit2_clk[n]));
                lit($sformatf("f2_tick_e%0d", n + 1), int'(if2.tick),    int'(lit2_tick[n]));
            end
            lit($sformatf("f5_clk_e%0d", n + 1),  int'(if1.clk_out), int'(lit5_clk[n]));
            lit($sformatf("f5_tick_e%0d", n + 1), int'(if1.tick),    int'(lit5_tick[n]));
        end

        // Drop en mid-period on F=6, then confirm a clean restart.
        if3.en = 1'b0;
        repeat (3) @(negedge clk);
        lit("f6_off_clk_out", int'(if3.clk_out), 0);
        lit("f6_off_tick",    int'(if3.tick), 0);
        lit("f6_off_count",   int'(cnt3), 0);
        if3.en = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            lit($sformatf("f6_clk_e%0d", n + 1),   int'(if3.clk_out), int'(lit6_clk[n]));
            lit($sformatf("f6_tick_e%0d", n + 1),  int'(if3.tick),    int'(lit6_tick[n]));
            lit($sformatf("f6_count_e%0d", n + 1), int'(cnt3),        lit6_cnt[n]);
        end

        // Large ratio: locate a rising edge, measure one period, then a 3-period window.
        found = 1'b0;
        prev  = if4.clk_out;
        for (int i = 0; i < 2 * FB && !found; i++) begin
            @(negedge clk);
            if (if4.clk_out && !prev) found = 1'b1;
            prev = if4.clk_out;
        end
        lit("fbig_rise_found", int'(found), 1);
        period = 0;
        found  = 1'b0;
        for (int i = 0; i < 2 * FB && !found; i++) begin
            @(negedge clk);
            period++;
            if (if4.clk_out && !prev) found = 1'b1;
            prev = if4.clk_out;
        end
        lit("fbig_period", period, FB);
        ticks = 0;
        highs = 0;
        repeat (3 * FB) begin
            @(negedge clk);
            if (if4.tick) ticks++;
            if (if4.clk_out) highs++;
        end
        lit("fbig_ticks", ticks, 3);
        lit("fbig_high_cycles", highs, 3 * (FB / 2));

        // Asynchronous reset between edges must clear outputs before the next edge.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        lit("async_fbig_count",  int'(cnt4), 0);
        lit("async_f2_count",    int'(cnt2), 0);
        lit("async_f4_clk_out",  int'(if0.clk_out), 0);
        lit("async_f5_count",    int'(cnt1), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
